multicycle_control_unit: RTL and testbench

//   Parametrised multicycle RV32I control FSM; successor to the single-cycle ControlUnit.

---
 rtl/multicycle_control_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB over a shared
// memory with a ready handshake and a wait-state timeout.
// Optional feature: define PERF_CNT_EN to add cycle_cnt/instret_cnt outputs.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic [3:0] state_o,
  output logic       retire,
  output logic       illegal,
  output logic       mem_timeout
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

  // Out-of-range parameter values elaborate an empty, easily spotted block.
  if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_unsupported_params
  end

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        funct_alu;
  logic              timeout_hit, decode_illegal;
  logic              mem_req_r, mem_write_r, ir_write_r, pc_write_r, reg_write_r, retire_r;

  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (funct7_5 && opcode[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next     = state;
    mem_req_r      = 1'b0;
    mem_write_r    = 1'b0;
    ir_write_r     = 1'b0;
    pc_write_r     = 1'b0;
    reg_write_r    = 1'b0;
    retire_r       = 1'b0;
    adr_src        = 1'b0;
    alu_src_a      = 2'b00;
    alu_src_b      = 2'b00;
    imm_src        = 2'b00;
    result_src     = 2'b00;
    alu_control    = ALU_ADD;
    timeout_hit    = 1'b0;
    decode_illegal = 1'b0;
    case (state)
      FETCH: begin
        mem_req_r = 1'b1;
        alu_src_b = 2'b10;
        if (mem_ready) begin
          ir_write_r = 1'b1;
          pc_write_r = 1'b1;
          state_next = DECODE;
        end else if (wait_cnt == WAIT_MAX) begin
          timeout_hit = 1'b1;
          state_next  = TRAP;
        end
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            decode_illegal = 1'b1;
            state_next     = TRAP;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = opcode[5] ? 2'b01 : 2'b00;
        state_next = opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req_r = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          state_next = MEMWB;
        end else if (wait_cnt == WAIT_MAX) begin
          timeout_hit = 1'b1;
          state_next  = TRAP;
        end
      end
      MEMWRITE: begin
        mem_req_r   = 1'b1;
        mem_write_r = 1'b1;
        adr_src     = 1'b1;
        if (mem_ready) begin
          retire_r   = 1'b1;
          state_next = FETCH;
        end else if (wait_cnt == WAIT_MAX) begin
          timeout_hit = 1'b1;
          state_next  = TRAP;
        end
      end
      MEMWB: begin
        reg_write_r = 1'b1;
        result_src  = 2'b01;
        retire_r    = 1'b1;
        state_next  = FETCH;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = funct_alu;
        state_next  = ALUWB;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_alu;
        state_next  = ALUWB;
      end
      ALUWB: begin
        reg_write_r = 1'b1;
        retire_r    = 1'b1;
        state_next  = FETCH;
      end
      BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write_r  = zero;
        retire_r    = 1'b1;
        state_next  = FETCH;
      end
      JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        pc_write_r  = 1'b1;
        reg_write_r = 1'b1;
        retire_r    = 1'b1;
        state_next  = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FETCH;
      wait_cnt    <= '0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (decode_illegal) illegal <= 1'b1;
      if (timeout_hit) mem_timeout <= 1'b1;
      if (mem_req_r && !mem_ready && state_next == state) wait_cnt <= wait_cnt + 1'b1;
      else wait_cnt <= '0;
    end
  end

  // Synchronous reset still lets the old state decode, so enables are masked by reset.
  assign mem_req   = reset & mem_req_r;
  assign mem_write = reset & mem_write_r;
  assign ir_write  = reset & ir_write_r;
  assign pc_write  = reset & pc_write_r;
  assign reg_write = reset & reg_write_r;
  assign retire    = reset & retire_r;
  assign state_o   = state;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != TRAP) cycle_cnt <= cycle_cnt + 1'b1;
      if (retire_r) instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit (MEM_TIMEOUT=4, CNT_W=4).
// Counter checks are active when PERF_CNT_EN is defined.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;
  logic       retire, illegal, mem_timeout;
`ifdef PERF_CNT_EN
  logic [3:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .result_src(result_src), .alu_control(alu_control), .state_o(state_o),
    .retire(retire), .illegal(illegal), .mem_timeout(mem_timeout)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7;
  localparam logic [3:0] S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;

  // enable order: mem_req, mem_write, adr_src, ir_write, pc_write, reg_write
  localparam logic [5:0] EN_NONE = 6'b000000, EN_FWAIT = 6'b100000, EN_FGO = 6'b100110;
  localparam logic [5:0] EN_RD = 6'b101000, EN_WR = 6'b111000, EN_RW = 6'b000001;
  localparam logic [5:0] EN_PC = 6'b000010, EN_JAL = 6'b000011;
  // flag order: retire, illegal, mem_timeout
  localparam logic [2:0] F_NONE = 3'b000, F_RET = 3'b100, F_ILL = 3'b010, F_TO = 3'b001;

  logic [23:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  perf_q[$];
  int          checks = 0;
  int          passes = 0;

  logic [23:0] act;
  assign act = {state_o, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, imm_src, result_src, alu_control,
                retire, illegal, mem_timeout};

  always @(negedge clk) begin
    logic [23:0] e;
    string       n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act === e) passes++;
      else $display("FAIL %s: got %b required %b", n, act, e);
    end
`ifdef PERF_CNT_EN
    if (perf_q.size() != 0) begin
      logic [7:0] p;
      p = perf_q.pop_front();
      checks++;
      if ({cycle_cnt, instret_cnt} === p) passes++;
      else $display("FAIL perf_counters: got cyc=%0d ret=%0d required cyc=%0d ret=%0d",
                    cycle_cnt, instret_cnt, p[7:4], p[3:0]);
    end
`endif
  end

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7_5 = f7;
  endtask

  task automatic cyc(input logic rst, input logic rdy, input logic zr, input string nm,
                     input logic [3:0] st, input logic [5:0] en, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] imm, input logic [1:0] res,
                     input logic [2:0] alu, input logic [2:0] fl);
    reset = rst; mem_ready = rdy; zero = zr;
    exp_q.push_back({st, en, a, b, imm, res, alu, fl});
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic fetch_ok();
    cyc(1, 1, 0, "fetch", S_FETCH, EN_FGO, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, F_NONE);
  endtask

  task automatic decode(input logic rdy);
    cyc(1, rdy, 0, "decode", S_DECODE, EN_NONE, 2'b01, 2'b01, 2'b10, 2'b00, 3'b000, F_NONE);
  endtask

  task automatic alu_op(input logic imm_form, input logic [2:0] alu, input string nm);
    cyc(1, 0, 0, nm, imm_form ? S_EXECI : S_EXECR, EN_NONE, 2'b10,
        imm_form ? 2'b01 : 2'b00, 2'b00, 2'b00, alu, F_NONE);
    cyc(1, 0, 0, "aluwb", S_ALUWB, EN_RW, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_RET);
  endtask

  task automatic perf_expect(input logic [3:0] cy, input logic [3:0] rt);
`ifdef PERF_CNT_EN
    perf_q.push_back({cy, rt});
`else
    if (cy != rt) begin end
`endif
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);
    @(posedge clk); #1;
    // Reset low with mem_ready high: FETCH decode but every enable masked.
    cyc(0, 1, 0, "reset", S_FETCH, EN_NONE, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, F_NONE);
    perf_expect(4'd0, 4'd0);

    // 17 adds: 68 cycles, instret wraps to 1, cycle_cnt to 4 (mod 16).
    for (int i = 0; i < 17; i++) begin
      fetch_ok();
      decode(0);
      alu_op(0, 3'b000, "add");
    end
    perf_expect(4'd4, 4'd1);

    // Reset mid-EXECR: no retire, counters cleared, restart in FETCH.
    fetch_ok();
    decode(0);
    cyc(0, 0, 0, "reset_execr", S_EXECR, EN_NONE, 2'b10, 2'b00, 2'b00, 2'b00, 3'b000, F_NONE);
    perf_expect(4'd0, 4'd0);
    cyc(1, 0, 0, "fetch_wait", S_FETCH, EN_FWAIT, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, F_NONE);

    set_instr(7'b0110011, 3'b000, 1'b1);
    fetch_ok(); decode(1); alu_op(0, 3'b001, "sub");
    set_instr(7'b0010011, 3'b000, 1'b1);
    fetch_ok(); decode(0); alu_op(1, 3'b000, "addi_f7");
    set_instr(7'b0010011, 3'b110, 1'b0);
    fetch_ok(); decode(0); alu_op(1, 3'b011, "ori");
    set_instr(7'b0110011, 3'b010, 1'b0);
    fetch_ok(); decode(0); alu_op(0, 3'b101, "slt");
    set_instr(7'b0110011, 3'b111, 1'b0);
    fetch_ok(); decode(0); alu_op(0, 3'b010, "and");

    // lw with 3 stall cycles; ready on the 4th beats the timeout.
    set_instr(7'b0000011, 3'b010, 1'b0);
    fetch_ok(); decode(0);
    cyc(1, 0, 0, "lw_memadr", S_MEMADR, EN_NONE, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, F_NONE);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, "lw_wait", S_MEMREAD, EN_RD, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_NONE);
    cyc(1, 1, 0, "lw_ready", S_MEMREAD, EN_RD, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_NONE);
    cyc(1, 0, 0, "lw_memwb", S_MEMWB, EN_RW, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, F_RET);

    set_instr(7'b0100011, 3'b010, 1'b0);
    fetch_ok(); decode(0);
    cyc(1, 0, 0, "sw_memadr", S_MEMADR, EN_NONE, 2'b10, 2'b01, 2'b01, 2'b00, 3'b000, F_NONE);
    cyc(1, 0, 0, "sw_wait", S_MEMWRITE, EN_WR, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_NONE);
    cyc(1, 1, 0, "sw_ready", S_MEMWRITE, EN_WR, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_RET);

    set_instr(7'b1100011, 3'b000, 1'b0);
    fetch_ok(); decode(0);
    cyc(1, 0, 1, "beq_taken", S_BEQ, EN_PC, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, F_RET);
    fetch_ok(); decode(0);
    cyc(1, 0, 0, "beq_not", S_BEQ, EN_NONE, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, F_RET);

    set_instr(7'b1101111, 3'b000, 1'b0);
    fetch_ok(); decode(0);
    cyc(1, 0, 0, "jal", S_JAL, EN_JAL, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, F_RET);

    // Illegal opcode traps; TRAP ignores mem_ready and holds until reset.
    set_instr(7'b1111111, 3'b000, 1'b0);
    fetch_ok(); decode(0);
    cyc(1, 1, 0, "trap_ill", S_TRAP, EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_ILL);
    cyc(1, 0, 0, "trap_hold", S_TRAP, EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_ILL);
    cyc(0, 0, 0, "trap_rst", S_TRAP, EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_ILL);

    // Four stalled FETCH cycles, then timeout trap.
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 0, "fetch_stall", S_FETCH, EN_FWAIT, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, F_NONE);
    cyc(1, 1, 0, "trap_to", S_TRAP, EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_TO);
    cyc(0, 0, 0, "trap_to_rst", S_TRAP, EN_NONE, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, F_TO);
    fetch_ok();

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
